// File: rtl/frame_check.sv
// AXI-Stream video sink that checks the {00, v, h} test pattern plus SOF/EOL placement
// on each accepted beat, with optional LFSR-driven backpressure on pix_tready.
module frame_check #(
    parameter bit          BP_EN   = 1'b0,
    parameter logic [15:0] BP_SEED = 16'hACE1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [15:0] H_RES,
    input  logic [15:0] V_RES,
    input  logic        enable,
    input  logic        pix_tvalid,
    output logic        pix_tready,
    input  logic [23:0] pix_tdata,
    input  logic        pix_tlast,
    input  logic        pix_tuser,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] frame_cnt,
    output logic [31:0] pix_err_cnt,
    output logic [31:0] sync_err_cnt,
    output logic [31:0] drop_cnt
);

    typedef enum logic {WAIT_SOF, ACTIVE} state_t;

    state_t      state, state_next;
    logic [15:0] lfsr;
    logic [15:0] h, v, h_next, v_next;
    logic [15:0] h_res, v_res;
    logic        frame_bad, bad_next;
    logic        done_next, ok_next;

    logic        beat, restart, new_frame, take;
    logic [15:0] cur_h, cur_v, cur_hres, cur_vres;
    logic        at_eol, on_last_line, line_end, frame_end;
    logic        pix_err, tlast_err, beat_bad;

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    // A mid-frame tuser closes the current frame and reinterprets this beat as pixel (0,0).
    always_comb begin
        beat         = pix_tvalid && pix_tready;
        restart      = (state == ACTIVE) && pix_tuser && ((h != 16'd0) || (v != 16'd0));
        new_frame    = ((state == WAIT_SOF) && pix_tuser) || restart;
        take         = beat && ((state == ACTIVE) || pix_tuser);
        cur_h        = new_frame ? 16'd0 : h;
        cur_v        = new_frame ? 16'd0 : v;
        cur_hres     = new_frame ? H_RES : h_res;
        cur_vres     = new_frame ? V_RES : v_res;
        at_eol       = (cur_h == cur_hres - 16'd1);
        on_last_line = (cur_v == cur_vres - 16'd1);
        line_end     = pix_tlast || at_eol;
        frame_end    = line_end && on_last_line;
        pix_err      = (pix_tdata != {8'h00, cur_v[7:0], cur_h[7:0]});
        tlast_err    = (pix_tlast != at_eol);
        beat_bad     = pix_err || tlast_err;
    end

    always_comb begin
        state_next = state;
        h_next     = h;
        v_next     = v;
        bad_next   = frame_bad;
        done_next  = 1'b0;
        ok_next    = frame_ok;
        if (take) begin
            if (frame_end) begin
                state_next = WAIT_SOF;
                h_next     = 16'd0;
                v_next     = 16'd0;
                bad_next   = 1'b0;
                done_next  = 1'b1;
                ok_next    = !(restart || (!new_frame && frame_bad) || beat_bad);
            end else begin
                state_next = ACTIVE;
                bad_next   = (!new_frame && frame_bad) || beat_bad;
                if (line_end) begin
                    h_next = 16'd0;
                    v_next = cur_v + 16'd1;
                end else begin
                    h_next = cur_h + 16'd1;
                    v_next = cur_v;
                end
                if (restart) begin
                    done_next = 1'b1;
                    ok_next   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) state <= WAIT_SOF;
        else        state <= state_next;
    end

    // The LFSR free-runs every cycle so the ready pattern does not depend on traffic.
    always_ff @(posedge aclk) begin
        if (areset) begin
            lfsr         <= BP_SEED;
            pix_tready   <= 1'b0;
            h            <= 16'd0;
            v            <= 16'd0;
            h_res        <= 16'd0;
            v_res        <= 16'd0;
            frame_bad    <= 1'b0;
            frame_done   <= 1'b0;
            frame_ok     <= 1'b0;
            frame_cnt    <= 16'd0;
            pix_err_cnt  <= 32'd0;
            sync_err_cnt <= 32'd0;
            drop_cnt     <= 32'd0;
        end else begin
            lfsr       <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            pix_tready <= enable && (!BP_EN || lfsr[0]);
            h          <= h_next;
            v          <= v_next;
            frame_bad  <= bad_next;
            frame_done <= done_next;
            frame_ok   <= ok_next;
            if (take && new_frame) begin
                h_res <= H_RES;
                v_res <= V_RES;
            end
            if (done_next)
                frame_cnt <= frame_cnt + 16'd1;
            if (take && pix_err)
                pix_err_cnt <= sat_inc(pix_err_cnt);
            if (take && (tlast_err || restart))
                sync_err_cnt <= sat_inc(sync_err_cnt);
            if (beat && (state == WAIT_SOF) && !pix_tuser)
                drop_cnt <= sat_inc(drop_cnt);
        end
    end

    assign busy = (state == ACTIVE);

endmodule

// File: tb/tb_frame_check.sv
// Self-checking bench for frame_check: directed frame scenarios plus randomized frames
// compared against a pixel-index model (h = i % H, v = i / H).
module tb_frame_check;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [15:0] H_RES = 16'd4;
    logic [15:0] V_RES = 16'd3;
    logic        enable = 1'b1;
    logic        pix_tvalid = 1'b0;
    logic [23:0] pix_tdata = 24'd0;
    logic        pix_tlast = 1'b0;
    logic        pix_tuser = 1'b0;
    logic        use_bp = 1'b0;

    logic        rdy_a, busy_a, done_a, ok_a;
    logic [15:0] fcnt_a;
    logic [31:0] perr_a, serr_a, drop_a;
    logic        rdy_b, busy_b, done_b, ok_b;
    logic [15:0] fcnt_b;
    logic [31:0] perr_b, serr_b, drop_b;

    logic        rdy, busy, frame_done, frame_ok;
    logic [15:0] frame_cnt;
    logic [31:0] pix_err_cnt, sync_err_cnt, drop_cnt;

    int n_checks = 0;
    int n_pass = 0;
    int done_seen = 0;

    always #5 aclk = ~aclk;

    frame_check #(.BP_EN(1'b0), .BP_SEED(16'hACE1)) dut (
        .aclk(aclk), .areset(areset), .H_RES(H_RES), .V_RES(V_RES), .enable(enable),
        .pix_tvalid(pix_tvalid && !use_bp), .pix_tready(rdy_a), .pix_tdata(pix_tdata),
        .pix_tlast(pix_tlast), .pix_tuser(pix_tuser), .busy(busy_a), .frame_done(done_a),
        .frame_ok(ok_a), .frame_cnt(fcnt_a), .pix_err_cnt(perr_a), .sync_err_cnt(serr_a),
        .drop_cnt(drop_a));

    frame_check #(.BP_EN(1'b1), .BP_SEED(16'hACE1)) dut_bp (
        .aclk(aclk), .areset(areset), .H_RES(H_RES), .V_RES(V_RES), .enable(enable),
        .pix_tvalid(pix_tvalid && use_bp), .pix_tready(rdy_b), .pix_tdata(pix_tdata),
        .pix_tlast(pix_tlast), .pix_tuser(pix_tuser), .busy(busy_b), .frame_done(done_b),
        .frame_ok(ok_b), .frame_cnt(fcnt_b), .pix_err_cnt(perr_b), .sync_err_cnt(serr_b),
        .drop_cnt(drop_b));

    assign rdy          = use_bp ? rdy_b  : rdy_a;
    assign busy         = use_bp ? busy_b : busy_a;
    assign frame_done   = use_bp ? done_b : done_a;
    assign frame_ok     = use_bp ? ok_b   : ok_a;
    assign frame_cnt    = use_bp ? fcnt_b : fcnt_a;
    assign pix_err_cnt  = use_bp ? perr_b : perr_a;
    assign sync_err_cnt = use_bp ? serr_b : serr_a;
    assign drop_cnt     = use_bp ? drop_b : drop_a;

    always @(posedge aclk) if (frame_done) done_seen <= done_seen + 1;

    function automatic logic [23:0] pix(input int hh, input int vv);
        return {8'h00, 8'(vv), 8'(hh)};
    endfunction

    task automatic do_reset();
        pix_tvalid = 1'b0;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    // Presents one beat after an optional random idle gap and returns just after it is accepted.
    task automatic send_beat(input logic [23:0] d, input logic l, input logic u, input int gap);
        int k;
        if (gap > 0) begin
            pix_tvalid = 1'b0;
            repeat ($urandom_range(0, gap)) begin @(posedge aclk); #1; end
        end
        pix_tdata = d; pix_tlast = l; pix_tuser = u; pix_tvalid = 1'b1;
        k = 0;
        while (!rdy && k < 200) begin @(posedge aclk); #1; k++; end
        if (k >= 200) begin
            n_checks++;
            $display("[TB] FAIL beat_timeout tready stuck at %0b, wanted 1 within 200 cycles", rdy);
        end else begin
            @(posedge aclk);
            #1;
        end
        pix_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int hr, input int vr, input int gap, input bit corrupt,
                              output int nc);
        logic [23:0] d;
        int hh, vv;
        H_RES = 16'(hr); V_RES = 16'(vr); nc = 0;
        for (int i = 0; i < hr * vr; i++) begin
            hh = i % hr; vv = i / hr;
            d = pix(hh, vv);
            if (corrupt && $urandom_range(0, 7) == 0) begin
                d = d ^ (24'd1 << $urandom_range(0, 23));
                nc++;
            end
            send_beat(d, hh == hr - 1, i == 0, gap);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        n_checks++; if (rdy !== 1'b0) $display("[TB] FAIL rst_tready got %0b want 0", rdy); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy got %0b want 0", busy); else n_pass++;
        n_checks++; if (frame_done !== 1'b0 || frame_ok !== 1'b0) $display("[TB] FAIL rst_done_ok got %0b%0b want 00", frame_done, frame_ok); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd0) $display("[TB] FAIL rst_frame_cnt got %0d want 0", frame_cnt); else n_pass++;
        n_checks++; if (pix_err_cnt !== 32'd0 || sync_err_cnt !== 32'd0 || drop_cnt !== 32'd0) $display("[TB] FAIL rst_err_cnts got %0d/%0d/%0d want 0/0/0", pix_err_cnt, sync_err_cnt, drop_cnt); else n_pass++;
        areset = 1'b0;
        @(posedge aclk);
        #1;
        n_checks++; if (rdy !== 1'b1) $display("[TB] FAIL rst_tready_after got %0b want 1", rdy); else n_pass++;
    endtask

    task automatic test_compliant();
        int nc;
        do_reset();
        send_beat(pix(0, 0), 1'b0, 1'b1, 2);
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL t1_busy got %0b want 1", busy); else n_pass++;
        for (int i = 1; i < 12; i++) send_beat(pix(i % 4, i / 4), (i % 4) == 3, 1'b0, 2);
        n_checks++; if (frame_done !== 1'b1 || frame_ok !== 1'b1) $display("[TB] FAIL t1_done_ok got %0b%0b want 11", frame_done, frame_ok); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd1) $display("[TB] FAIL t1_frame_cnt got %0d want 1", frame_cnt); else n_pass++;
        n_checks++; if (pix_err_cnt !== 32'd0 || sync_err_cnt !== 32'd0) $display("[TB] FAIL t1_errs got %0d/%0d want 0/0", pix_err_cnt, sync_err_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL t1_busy_end got %0b want 0", busy); else n_pass++;
        @(posedge aclk);
        #1;
        n_checks++; if (frame_done !== 1'b0 || frame_ok !== 1'b1) $display("[TB] FAIL t1_pulse_hold got %0b%0b want 01", frame_done, frame_ok); else n_pass++;
        nc = 0;
    endtask

    task automatic test_pix_err();
        do_reset();
        H_RES = 16'd4; V_RES = 16'd3;
        for (int i = 0; i < 12; i++)
            send_beat((i == 6) ? 24'h000103 : pix(i % 4, i / 4), (i % 4) == 3, i == 0, 1);
        n_checks++; if (pix_err_cnt !== 32'd1) $display("[TB] FAIL t2_pix_err got %0d want 1", pix_err_cnt); else n_pass++;
        n_checks++; if (sync_err_cnt !== 32'd0) $display("[TB] FAIL t2_sync_err got %0d want 0", sync_err_cnt); else n_pass++;
        n_checks++; if (frame_done !== 1'b1 || frame_ok !== 1'b0) $display("[TB] FAIL t2_done_ok got %0b%0b want 10", frame_done, frame_ok); else n_pass++;
    endtask

    task automatic test_drop();
        int nc, hr, vr;
        do_reset();
        for (int i = 0; i < 3; i++) send_beat(24'($urandom), 1'($urandom), 1'b0, 1);
        hr = $urandom_range(1, 6); vr = $urandom_range(1, 4);
        send_frame(hr, vr, 1, 1'b0, nc);
        n_checks++; if (drop_cnt !== 32'd3) $display("[TB] FAIL t3_drop got %0d want 3", drop_cnt); else n_pass++;
        n_checks++; if (frame_ok !== 1'b1 || frame_cnt !== 16'd1) $display("[TB] FAIL t3_ok_cnt got %0b/%0d want 1/1 (H=%0d V=%0d)", frame_ok, frame_cnt, hr, vr); else n_pass++;
    endtask

    task automatic test_mid_sof();
        do_reset();
        H_RES = 16'd4; V_RES = 16'd3;
        for (int i = 0; i < 5; i++) send_beat(pix(i % 4, i / 4), (i % 4) == 3, i == 0, 1);
        send_beat(pix(0, 0), 1'b0, 1'b1, 1);
        n_checks++; if (frame_done !== 1'b1 || frame_ok !== 1'b0) $display("[TB] FAIL t4_abort_done_ok got %0b%0b want 10", frame_done, frame_ok); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd1 || sync_err_cnt !== 32'd1) $display("[TB] FAIL t4_abort_cnts got %0d/%0d want 1/1", frame_cnt, sync_err_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL t4_busy got %0b want 1", busy); else n_pass++;
        for (int i = 1; i < 12; i++) send_beat(pix(i % 4, i / 4), (i % 4) == 3, 1'b0, 1);
        n_checks++; if (frame_done !== 1'b1 || frame_ok !== 1'b1) $display("[TB] FAIL t4_new_done_ok got %0b%0b want 11", frame_done, frame_ok); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd2 || pix_err_cnt !== 32'd0 || sync_err_cnt !== 32'd1) $display("[TB] FAIL t4_final got %0d/%0d/%0d want 2/0/1", frame_cnt, pix_err_cnt, sync_err_cnt); else n_pass++;
    endtask

    task automatic test_early_tlast();
        do_reset();
        H_RES = 16'd4; V_RES = 16'd3;
        send_beat(pix(0, 0), 1'b0, 1'b1, 1);
        send_beat(pix(1, 0), 1'b1, 1'b0, 1);
        n_checks++; if (sync_err_cnt !== 32'd1) $display("[TB] FAIL t5_sync got %0d want 1", sync_err_cnt); else n_pass++;
        send_beat(24'h000100, 1'b0, 1'b0, 1);
        n_checks++; if (pix_err_cnt !== 32'd0) $display("[TB] FAIL t5_resync_pix got %0d want 0", pix_err_cnt); else n_pass++;
        for (int i = 5; i < 12; i++) send_beat(pix(i % 4, i / 4), (i % 4) == 3, 1'b0, 1);
        n_checks++; if (frame_done !== 1'b1 || frame_ok !== 1'b0 || frame_cnt !== 16'd1) $display("[TB] FAIL t5_end got %0b%0b/%0d want 10/1", frame_done, frame_ok, frame_cnt); else n_pass++;
        n_checks++; if (pix_err_cnt !== 32'd0 || sync_err_cnt !== 32'd1) $display("[TB] FAIL t5_errs got %0d/%0d want 0/1", pix_err_cnt, sync_err_cnt); else n_pass++;
    endtask

    task automatic test_boundaries();
        int nc;
        do_reset();
        H_RES = 16'd1; V_RES = 16'd1;
        send_beat(24'h000000, 1'b1, 1'b1, 1);
        n_checks++; if (frame_done !== 1'b1 || frame_ok !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL b_single got %0b%0b%0b want 110", frame_done, frame_ok, busy); else n_pass++;
        send_frame(300, 1, 0, 1'b0, nc);
        n_checks++; if (frame_ok !== 1'b1 || pix_err_cnt !== 32'd0 || frame_cnt !== 16'd2) $display("[TB] FAIL b_wide got %0b/%0d/%0d want 1/0/2", frame_ok, pix_err_cnt, frame_cnt); else n_pass++;
        send_frame(1, 3, 1, 1'b0, nc);
        n_checks++; if (frame_ok !== 1'b1 || sync_err_cnt !== 32'd0 || frame_cnt !== 16'd3) $display("[TB] FAIL b_h1 got %0b/%0d/%0d want 1/0/3", frame_ok, sync_err_cnt, frame_cnt); else n_pass++;
        H_RES = 16'd2; V_RES = 16'd2;
        send_beat(pix(0, 0), 1'b0, 1'b1, 1);
        send_beat(pix(1, 0), 1'b0, 1'b0, 1);
        send_beat(pix(0, 1), 1'b0, 1'b0, 1);
        send_beat(pix(1, 1), 1'b1, 1'b0, 1);
        n_checks++; if (frame_done !== 1'b1 || frame_ok !== 1'b0 || sync_err_cnt !== 32'd1 || pix_err_cnt !== 32'd0) $display("[TB] FAIL b_missing_tlast got %0b%0b/%0d/%0d want 10/1/0", frame_done, frame_ok, sync_err_cnt, pix_err_cnt); else n_pass++;
    endtask

    task automatic test_random();
        int nc, hr, vr, exp_pix, exp_frames;
        do_reset();
        exp_pix = 0; exp_frames = 0;
        for (int f = 0; f < 6; f++) begin
            hr = $urandom_range(1, 7); vr = $urandom_range(1, 5);
            send_frame(hr, vr, 3, 1'b1, nc);
            exp_pix += nc; exp_frames++;
            n_checks++; if (frame_done !== 1'b1 || frame_ok !== (nc == 0)) $display("[TB] FAIL rnd_ok f%0d got %0b%0b want 1%0b", f, frame_done, frame_ok, nc == 0); else n_pass++;
            n_checks++; if (pix_err_cnt !== 32'(exp_pix) || frame_cnt !== 16'(exp_frames)) $display("[TB] FAIL rnd_cnts f%0d got %0d/%0d want %0d/%0d", f, pix_err_cnt, frame_cnt, exp_pix, exp_frames); else n_pass++;
        end
        n_checks++; if (sync_err_cnt !== 32'd0 || drop_cnt !== 32'd0) $display("[TB] FAIL rnd_sync_drop got %0d/%0d want 0/0", sync_err_cnt, drop_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nc, start_done, held;
        use_bp = 1'b1;
        do_reset();
        start_done = done_seen;
        for (int f = 0; f < 3; f++) send_frame(5, 2, 0, 1'b0, nc);
        @(posedge aclk);
        #1;
        n_checks++; if (frame_cnt !== 16'd3 || done_seen !== start_done + 3) $display("[TB] FAIL b2b_frames got %0d/%0d want 3/3", frame_cnt, done_seen - start_done); else n_pass++;
        n_checks++; if (pix_err_cnt !== 32'd0 || sync_err_cnt !== 32'd0 || drop_cnt !== 32'd0 || frame_ok !== 1'b1) $display("[TB] FAIL b2b_errs got %0d/%0d/%0d ok=%0b want 0/0/0 ok=1", pix_err_cnt, sync_err_cnt, drop_cnt, frame_ok); else n_pass++;
        for (int i = 0; i < 4; i++) send_beat(pix(i % 5, i / 5), 1'b0, i == 0, 0);
        held = done_seen;
        areset = 1'b1;
        @(posedge aclk);
        #1;
        n_checks++; if (rdy !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL mid_rst_rdy_busy got %0b%0b want 00", rdy, busy); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd0 || pix_err_cnt !== 32'd0 || frame_ok !== 1'b0) $display("[TB] FAIL mid_rst_cnts got %0d/%0d ok=%0b want 0/0 ok=0", frame_cnt, pix_err_cnt, frame_ok); else n_pass++;
        areset = 1'b0;
        repeat (4) @(posedge aclk);
        #1;
        n_checks++; if (done_seen !== held) $display("[TB] FAIL mid_rst_no_done got %0d pulses want 0", done_seen - held); else n_pass++;
        use_bp = 1'b0;
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog simulation time limit reached, wanted completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_compliant();
        test_pix_err();
        test_drop();
        test_mid_sof();
        test_early_tlast();
        test_boundaries();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
